uart_tx_periph: RTL and testbench
=================================

Name: uart_tx_periph

Overview:
Memory-mapped UART transmitter on the SOC data port, downstream of the CPU store path and alongside the LED register.
- SOC decodes the base address and drives `bus_sel`.
- CPU stores to DATA enqueue bytes into a small FIFO.
- A baud-timed FSM serialises queued bytes 8N1 on `tx`.
- STATUS is readable so firmware can poll before writing.

Parameters:
- CLKS_PER_BIT, 217: clock cycles per serial bit (25 MHz / 115200); legal range ≥ 2.
- FIFO_DEPTH, 8: byte entries in the TX FIFO; must be a power of two, ≥ 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- bus_sel  in  1  SOC address decode hit for this peripheral.
- bus_addr  in  4  byte offset within the peripheral; only [3:2] are used.
- bus_wdata  in  32  CPU write data.
- bus_wenable  in  1  CPU write strobe.
- bus_rdata  out  32  combinational read data.
- tx  out  1  serial line, idle high.

Behaviour:
- Register map (offset in `bus_addr[3:2]`):
  - 0 DATA: write pushes `bus_wdata[7:0]`; reads as 0.
  - 1 STATUS: read-only bits, plus write-1-to-clear on bit3.
    - bit0 busy (FSM not IDLE).
    - bit1 full.
    - bit2 empty.
    - bit3 overflow (sticky); writing bit3=1 clears it.
  - 2, 3: reads 0; writes ignored.
- `bus_rdata` is combinational from current state.
  - It is 0 when `bus_sel`=0.
  - No read side effects.
- Push condition: `bus_sel` & `bus_wenable` & offset 0.
  - "full" is the pre-edge value.
  - A push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
- Simultaneous push and pop when neither full nor empty: count is unchanged and both pointers advance.
- Overflow set and clear in the same cycle: set wins.
- Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
- FSM states: IDLE, START, DATA, STOP. Each non-IDLE state lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that restarts on every state entry.
  - IDLE: `tx`=1. If the FIFO is non-empty at an edge, pop the head into the shift register and enter START.
  - START: `tx`=0.
  - DATA: `tx`=shift[0], LSB first. Shift right each bit period. A 3-bit counter moves to STOP after bit 7.
  - STOP: `tx`=1. At end of the period, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency: a DATA write captured at edge E0 is popped at E1, and `tx` falls after E1.
  - A frame is 10·CLKS_PER_BIT cycles.
  - Back-to-back frames are contiguous.
- `tx` is registered; no glitches.
- Reset values: `tx`=1, state IDLE, FIFO empty, pointers 0, overflow 0, baud and bit counters 0, shift register 0.
- Reset asserted mid-frame aborts the frame: `tx` returns high on the next edge and queued bytes are discarded.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - `tx` = even parity, i.e. XOR of the 8 data bits.
  - Frame becomes 11·CLKS_PER_BIT cycles.
- When undefined: no PARITY state, 8N1 framing, and no parity logic is synthesised.

Decomposition:
- Package `uart_pkg`:
  - FSM state encoding.
  - Register offset constants (OFF_DATA=0, OFF_STATUS=1).
  - STATUS bit index constants.
- Sub-module `sync_fifo`, parameterised by width and depth:
  - Ports: push/pop/din/dout/full/empty.
  - First-word-fall-through dout.
  - Instantiated once with width 8.
- The FSM and register decode stay in `uart_tx_periph`.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
1. Reset, then idle 20 cycles -> `tx`=1 throughout; STATUS reads 0x4.
2. Write 0x55 to DATA -> `tx` falls one edge after the write; the sampled line over 40 cycles is 0,1,0,1,0,1,0,1,0,1, then `tx` stays high; busy reads 1 during the frame and 0 after.
3. Write 0xA5 and 0x3C on consecutive cycles -> two contiguous 40-cycle frames with no idle gap; STATUS=0x4 after 80 cycles.
4. Six writes in six consecutive cycles -> first byte popped at E1, full asserts; the sixth write is dropped and overflow=1 (STATUS bit3); exactly 5 frames transmitted; writing 0x8 to STATUS clears overflow.
5. Assert reset at cycle 15 of a frame -> `tx`=1 on the next edge; STATUS=0x4; no further frames start.
6. Parity build, write 0x07 -> frame 0, 1,1,1,0,0,0,0,0, parity 1, stop 1 (44 cycles); read offset 2 -> 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// register offsets and STATUS bit positions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through output; pushes while
// full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign dout  = mem_r[rd_ptr_r];

  always_comb begin
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
  end

  // Storage, wrapping pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: DATA/STATUS register decode, TX FIFO and a
// baud-timed frame FSM. Define UART_TX_PARITY_EN for an even-parity bit.
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_sel,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_wenable,
  output logic [31:0] bus_rdata,
  output logic        tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  uart_state_e state_r, state_next_s;
  logic [BW-1:0] baud_cnt_r;
  logic [2:0]    bit_cnt_r, bit_cnt_next_s;
  logic [7:0]    shift_r, shift_next_s;
  logic          tx_r, tx_next_s;
  logic          ovf_r;
  logic          baud_done_s, pop_s, push_req_s, ovf_clr_s;
  logic [7:0]    fifo_dout_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [3:0]    status_s;
  logic          unused_bits_s;
`ifdef UART_TX_PARITY_EN
  logic          parity_r;
`endif

  assign unused_bits_s = &{1'b0, bus_addr[1:0], bus_wdata[31:8]};
  assign tx = tx_r;

  always_comb begin
    push_req_s  = bus_sel & bus_wenable & (bus_addr[3:2] == OFF_DATA);
    ovf_clr_s   = bus_sel & bus_wenable & (bus_addr[3:2] == OFF_STATUS) & bus_wdata[STAT_OVF];
    baud_done_s = (baud_cnt_r == BW'(CLKS_PER_BIT - 1));
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req_s),
    .pop   (pop_s),
    .din   (bus_wdata[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state, pop and shift/bit-counter updates
  always_comb begin
    state_next_s   = state_r;
    pop_s          = 1'b0;
    shift_next_s   = shift_r;
    bit_cnt_next_s = bit_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          shift_next_s = fifo_dout_s;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_done_s) begin
          state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_done_s) begin
          shift_next_s   = shift_r >> 1;
          bit_cnt_next_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next_s = ST_PARITY;
`else
            state_next_s = ST_STOP;
`endif
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_done_s) begin
          state_next_s = ST_STOP;
        end else begin
          state_next_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        // A queued byte starts the next frame with no idle gap
        if (baud_done_s && !fifo_empty_s) begin
          pop_s        = 1'b1;
          shift_next_s = fifo_dout_s;
          state_next_s = ST_START;
        end else if (baud_done_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Line level for the upcoming state, registered so tx never glitches
  always_comb begin
    tx_next_s = 1'b1;
    case (state_next_s)
      ST_IDLE:   tx_next_s = 1'b1;
      ST_START:  tx_next_s = 1'b0;
      ST_DATA:   tx_next_s = shift_next_s[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next_s = parity_r;
`endif
      ST_STOP:   tx_next_s = 1'b1;
      default:   tx_next_s = 1'b1;
    endcase
  end

  // FSM state, baud timing, shift register and tx
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= {BW{1'b0}};
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
      tx_r       <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      baud_cnt_r <= (state_r == ST_IDLE || baud_done_s) ? {BW{1'b0}} : baud_cnt_r + BW'(1);
      bit_cnt_r  <= bit_cnt_next_s;
      shift_r    <= shift_next_s;
      tx_r       <= tx_next_s;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is latched with the byte because the shift register consumes it
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_r <= 1'b0;
    end else if (pop_s) begin
      parity_r <= even_parity(fifo_dout_s);
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  // Sticky overflow; a dropped push wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (push_req_s && fifo_full_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Combinational read mux, free of side effects
  always_comb begin
    status_s = 4'd0;
    status_s[STAT_BUSY]  = (state_r != ST_IDLE);
    status_s[STAT_FULL]  = fifo_full_s;
    status_s[STAT_EMPTY] = fifo_empty_s;
    status_s[STAT_OVF]   = ovf_r;
    bus_rdata = 32'd0;
    if (bus_sel) begin
      case (bus_addr[3:2])
        OFF_STATUS: bus_rdata = {28'd0, status_s};
        default:    bus_rdata = 32'd0;
      endcase
    end else begin
      bus_rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Randomised scoreboard bench for uart_tx_periph with a frame-level reference
// model; also covers the build with UART_TX_PARITY_EN defined.
module tb_uart_tx_periph;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_sel = 1'b0;
  logic [3:0]  bus_addr = 4'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic        bus_wenable = 1'b0;
  logic [31:0] bus_rdata;
  logic        tx;

  always #5 clk = ~clk;

  uart_tx_periph #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_sel     (bus_sel),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wenable (bus_wenable),
    .bus_rdata   (bus_rdata),
    .tx          (tx)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: queued bytes, cycles left in the current frame, sticky overflow
  logic [7:0]       m_q[$];
  logic [7:0]       exp_q[$];
  int               m_rem = 0;
  logic [NBITS-1:0] m_frame = '0;
  logic             m_ovf = 1'b0;
  bit               m_valid = 1'b0;
  int               frames_done = 0;
  int               frames_rx = 0;
  int               epoch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  function automatic logic m_tx();
    if (m_rem == 0) return 1'b1;
    return m_frame[(FRAME - m_rem) / CPB];
  endfunction

  function automatic logic [31:0] m_rdata(input logic sel, input logic [3:0] addr);
    if (!sel || addr[3:2] != 2'd1) return 32'd0;
    return {28'd0, m_ovf, m_q.size() == 0, m_q.size() == DEPTH, m_rem != 0};
  endfunction

  // One bus cycle: check line and read data, drive inputs, advance the model past the next edge
  task automatic step(input logic sel, input logic wen, input logic [3:0] addr,
                      input logic [31:0] wd, input logic rst);
    bit full, empty, pop, push_req, clr;
    @(negedge clk);
    if (m_valid) check("tx_line", {31'd0, tx}, {31'd0, m_tx()});
    bus_sel = sel; bus_wenable = wen; bus_addr = addr; bus_wdata = wd; reset = rst;
    #1;
    if (m_valid) check("rdata", bus_rdata, m_rdata(sel, addr));
    full     = (m_q.size() == DEPTH);
    empty    = (m_q.size() == 0);
    push_req = sel && wen && addr[3:2] == 2'd0;
    clr      = sel && wen && addr[3:2] == 2'd1 && wd[3];
    pop      = !empty && (m_rem <= 1);
    if (rst) begin
      m_q.delete(); exp_q.delete();
      m_rem = 0; m_ovf = 1'b0; m_valid = 1'b1; epoch++;
    end else begin
      if (m_rem == 1) frames_done++;
      if (pop) begin
        m_frame = frame_of(m_q.pop_front());
        m_rem   = FRAME;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (push_req && full) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (push_req && !full) begin
        m_q.push_back(wd[7:0]);
        exp_q.push_back(wd[7:0]);
      end
    end
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] wd);
    step(1'b1, 1'b1, {off, 2'b00}, wd, 1'b0);
  endtask

  task automatic rd_status(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h4, 32'd0, 1'b0);
  endtask

  // Monitor: deserialise tx mid-bit and score each frame against the expected queue
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (m_valid && !reset && tx === 1'b0) begin
        int ep;
        logic [7:0] d;
        logic st, sp, par;
        ep = epoch;
        par = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        par = tx;
`endif
        repeat (CPB) @(negedge clk);
        sp = tx;
        if (ep == epoch) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL rx_unexpected: received frame 0x%0h, expected no frame", d);
          end else begin
            logic [7:0] b;
            b = exp_q.pop_front();
            frames_rx++;
            check("rx_data", {24'd0, d}, {24'd0, b});
            check("rx_start", {31'd0, st}, 32'd0);
            check("rx_stop", {31'd0, sp}, 32'd1);
`ifdef UART_TX_PARITY_EN
            check("rx_parity", {31'd0, par}, {31'd0, ^b});
`endif
          end
        end
      end
    end
  end

  initial begin : stimulus
    int rate[4];
    int r;
    int guard;
    rate = '{30, 5, 60, 0};

    // Reset, then idle with STATUS polled every cycle
    repeat (3) step(1'b0, 1'b0, 4'h0, 32'd0, 1'b1);
    rd_status(20);
    check("status_idle", bus_rdata, 32'h4);

    // Single byte: tx falls one edge after the write, busy during the frame
    wr(2'd0, 32'h55);
    rd_status(2);
    check("tx_start_bit", {31'd0, tx}, 32'd0);
    check("status_busy", bus_rdata, 32'h5);
    rd_status(FRAME + 8);
    check("status_after_frame", bus_rdata, 32'h4);

    // Two consecutive writes give contiguous frames
    wr(2'd0, 32'hA5);
    wr(2'd0, 32'h3C);
    rd_status(2 * FRAME + 4);
    check("status_after_pair", bus_rdata, 32'h4);

    // Six back-to-back writes: the sixth is dropped and overflow sets
    for (int i = 0; i < 6; i++) wr(2'd0, 32'h10 + i);
    rd_status(1);
    check("status_overflow", bus_rdata, 32'hB);
    rd_status(5 * FRAME + 8);
    check("status_drained_ovf", bus_rdata, 32'hC);
    wr(2'd1, 32'h8);
    rd_status(1);
    check("status_ovf_cleared", bus_rdata, 32'h4);

    // Reset in the middle of a frame aborts it
    wr(2'd0, 32'h96);
    wr(2'd0, 32'h69);
    rd_status(15);
    step(1'b1, 1'b0, 4'h4, 32'd0, 1'b1);
    rd_status(1);
    check("tx_after_reset", {31'd0, tx}, 32'd1);
    check("status_after_reset", bus_rdata, 32'h4);
    rd_status(FRAME + 20);

    // Byte 0x07 and unused offset reads 0
    wr(2'd0, 32'h07);
    step(1'b1, 1'b0, 4'h8, 32'd0, 1'b0);
    check("offset2_read", bus_rdata, 32'd0);
    rd_status(FRAME + 4);

    // Randomised phases with varying write pressure
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 400; c++) begin
        r = $urandom_range(0, 99);
        if (r < rate[p]) begin
          step(1'b1, 1'b1, {2'b00, 2'($urandom_range(0, 3))}, $urandom, 1'b0);
        end else begin
          case ($urandom_range(0, 9))
            0:       step(1'b1, 1'b1, 4'h4, $urandom, 1'b0);
            1:       step(1'b1, 1'b1, 4'($urandom_range(8, 15)), $urandom, 1'b0);
            2:       step(1'b0, 1'b1, 4'h0, $urandom, 1'b0);
            default: step(1'b1, 1'b0, 4'($urandom_range(0, 15)), 32'd0, 1'b0);
          endcase
        end
      end
    end

    // Drain everything still queued, bounded
    guard = 0;
    while ((m_rem != 0 || m_q.size() != 0) && guard < 600) begin
      rd_status(1);
      guard++;
    end
    if (guard >= 600) begin
      checks++;
      $display("FAIL drain_timeout: model still busy after %0d cycles, expected idle", guard);
    end
    rd_status(6);
    check("frames_received", frames_rx, frames_done);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("final_status", bus_rdata, m_rdata(1'b1, 4'h4));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
